// File: rtl/csr_perf_counters_pkg.sv
// Shared types, address constants and decode helpers for the machine counter/timer CSR bank.
package csr_perf_counters_pkg;

    localparam int HPM_FIRST = 3;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
    localparam logic [11:0] CSR_MHPMEVENT31   = 12'h33F;

    typedef struct packed {
        logic [31:3] hpm;
        logic        ir;
        logic        tm;
        logic        cy;
    } mcountinhibit_t;

    typedef enum logic [4:0] {
        EV_NONE         = 5'd0,
        EV_BRANCH_TAKEN = 5'd1,
        EV_LOAD         = 5'd2,
        EV_STORE        = 5'd3,
        EV_STALL        = 5'd4,
        EV_BRANCH_MISS  = 5'd5,
        EV_ICACHE_MISS  = 5'd6,
        EV_DCACHE_MISS  = 5'd7,
        EV_EXCEPTION    = 5'd8
    } hpm_event_t;

    // Counter space: 0xB00-0xB1F / 0xB80-0xB9F and the user aliases at 0xC00/0xC80.
    function automatic logic is_counter_addr(input logic [11:0] addr);
        return ((addr[11:8] == 4'hB) || (addr[11:8] == 4'hC)) && (addr[6:5] == 2'b00);
    endfunction

    function automatic logic is_user_alias(input logic [11:0] addr);
        return addr[11:8] == 4'hC;
    endfunction

    function automatic logic is_mhpmevent(input logic [11:0] addr);
        return (addr >= CSR_MHPMEVENT3) && (addr <= CSR_MHPMEVENT31);
    endfunction

    function automatic logic [4:0] csr_hpm_index(input logic [11:0] addr);
        return addr[4:0];
    endfunction

    function automatic logic [31:0] inhibit_wmask(input int num_hpm);
        logic [31:0] mask;
        mask = 32'h0000_0005;
        for (int i = 0; i < 29; i++) begin
            if (i < num_hpm) mask[HPM_FIRST+i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/csr_perf_counters_hpm_counter.sv
// One 64-bit event counter with independently writable halves; a write suppresses the increment.
module hpm_counter (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) count_d[31:0]  = wdata_i;
            if (wr_hi_i) count_d[63:32] = wdata_i;
        end else if (inc_i) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/csr_perf_counters.sv
// Machine counter/timer CSR bank: address decode, event selection and the registered read mux.
module csr_perf_counters
    import csr_perf_counters_pkg::*;
#(
    parameter int NUM_HPM    = 4,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  retired_i,
    input  logic [NUM_EVENTS-1:0] events_i,
    input  logic                  csr_read_enable_i,
    input  logic [11:0]           csr_read_addr_i,
    output logic [31:0]           csr_read_data_o,
    output logic                  csr_read_hit_o,
    input  logic                  csr_write_enable_i,
    input  logic [11:0]           csr_write_addr_i,
    input  logic [31:0]           csr_write_data_i,
    output logic                  csr_write_illegal_o
);

    // Slot 0 = mcycle, slot 1 = minstret, slot 2+i = mhpmcounter(3+i).
    localparam int NUM_CTR  = 2 + NUM_HPM;
    localparam int EV_SLOTS = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [31:0] INHIBIT_MASK = inhibit_wmask(NUM_HPM);

    logic [NUM_CTR-1:0] ctr_inc, ctr_wr_lo, ctr_wr_hi;
    logic [63:0]        ctr_count [NUM_CTR];

    mcountinhibit_t mcountinhibit_q, mcountinhibit_d;
    logic [31:0]    mhpmevent_q [EV_SLOTS];
    logic [31:0]    mhpmevent_d [EV_SLOTS];
    logic [31:0]    read_data_q, read_data_d;
    logic           read_hit_q, read_hit_d;
    logic           write_illegal_q, write_illegal_d;

    logic        wr_legal, wr_ctr, wr_upper;
    logic [4:0]  wr_idx, rd_idx;
    logic [63:0] rd_sel;

    assign wr_legal = csr_write_enable_i && !is_user_alias(csr_write_addr_i);
    assign wr_ctr   = wr_legal && is_counter_addr(csr_write_addr_i);
    assign wr_upper = csr_write_addr_i[7];
    assign wr_idx   = csr_hpm_index(csr_write_addr_i);
    assign rd_idx   = csr_hpm_index(csr_read_addr_i);

    always_comb begin
        ctr_wr_lo = '0;
        ctr_wr_hi = '0;
        if (wr_ctr) begin
            if (wr_idx == 5'd0) begin
                ctr_wr_lo[0] = !wr_upper;
                ctr_wr_hi[0] = wr_upper;
            end
            if (wr_idx == 5'd2) begin
                ctr_wr_lo[1] = !wr_upper;
                ctr_wr_hi[1] = wr_upper;
            end
            for (int i = 0; i < NUM_HPM; i++) begin
                if (wr_idx == 5'(HPM_FIRST + i)) begin
                    ctr_wr_lo[2+i] = !wr_upper;
                    ctr_wr_hi[2+i] = wr_upper;
                end
            end
        end
    end

    always_comb begin
        mcountinhibit_d = mcountinhibit_q;
        mhpmevent_d     = mhpmevent_q;
        if (wr_legal && (csr_write_addr_i == CSR_MCOUNTINHIBIT)) begin
            mcountinhibit_d = mcountinhibit_t'(csr_write_data_i & INHIBIT_MASK);
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            if (wr_legal && (csr_write_addr_i == CSR_MHPMEVENT3 + 12'(i))) begin
                mhpmevent_d[i] = csr_write_data_i;
            end
        end
        write_illegal_d = csr_write_enable_i && is_user_alias(csr_write_addr_i);
    end

    // Full 32-bit selector compare: zero or out-of-range selectors never match an event.
    always_comb begin
        ctr_inc    = '0;
        ctr_inc[0] = !mcountinhibit_q.cy;
        ctr_inc[1] = retired_i && !mcountinhibit_q.ir;
        for (int i = 0; i < NUM_HPM; i++) begin
            if (!mcountinhibit_q.hpm[HPM_FIRST+i]) begin
                for (int k = 0; k < NUM_EVENTS; k++) begin
                    if ((mhpmevent_q[i] == 32'(k + 1)) && events_i[k]) ctr_inc[2+i] = 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CTR; g++) begin : g_ctr
        hpm_counter u_ctr (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .inc_i   (ctr_inc[g]),
            .wr_lo_i (ctr_wr_lo[g]),
            .wr_hi_i (ctr_wr_hi[g]),
            .wdata_i (csr_write_data_i),
            .count_o (ctr_count[g])
        );
    end

    // Reads sample current state, so a same-cycle write is not yet visible.
    always_comb begin
        read_data_d = read_data_q;
        read_hit_d  = read_hit_q;
        rd_sel      = '0;
        if (csr_read_enable_i) begin
            read_data_d = '0;
            read_hit_d  = 1'b0;
            if (is_counter_addr(csr_read_addr_i)) begin
                if ((rd_idx == 5'd0) || ((rd_idx == 5'd1) && is_user_alias(csr_read_addr_i))) begin
                    read_hit_d = 1'b1;
                    rd_sel     = ctr_count[0];
                end else if (rd_idx == 5'd2) begin
                    read_hit_d = 1'b1;
                    rd_sel     = ctr_count[1];
                end else if (rd_idx >= 5'(HPM_FIRST)) begin
                    read_hit_d = 1'b1;
                    for (int i = 0; i < NUM_HPM; i++) begin
                        if (rd_idx == 5'(HPM_FIRST + i)) rd_sel = ctr_count[2+i];
                    end
                end
                read_data_d = csr_read_addr_i[7] ? rd_sel[63:32] : rd_sel[31:0];
            end else if (csr_read_addr_i == CSR_MCOUNTINHIBIT) begin
                read_hit_d  = 1'b1;
                read_data_d = mcountinhibit_q;
            end else if (is_mhpmevent(csr_read_addr_i)) begin
                read_hit_d = 1'b1;
                for (int i = 0; i < NUM_HPM; i++) begin
                    if (csr_read_addr_i == CSR_MHPMEVENT3 + 12'(i)) read_data_d = mhpmevent_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mcountinhibit_q <= '0;
            mhpmevent_q     <= '{default: '0};
            read_data_q     <= '0;
            read_hit_q      <= 1'b0;
            write_illegal_q <= 1'b0;
        end else begin
            mcountinhibit_q <= mcountinhibit_d;
            mhpmevent_q     <= mhpmevent_d;
            read_data_q     <= read_data_d;
            read_hit_q      <= read_hit_d;
            write_illegal_q <= write_illegal_d;
        end
    end

    assign csr_read_data_o     = read_data_q;
    assign csr_read_hit_o      = read_hit_q;
    assign csr_write_illegal_o = write_illegal_q;

endmodule

// File: tb/tb_csr_perf_counters.sv
// Directed and randomized bench for csr_perf_counters against an architectural counter model.
module tb_csr_perf_counters;

    localparam int NUM_HPM    = 4;
    localparam int NUM_EVENTS = 8;
    localparam logic [31:0] INH_MASK = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

    logic                  clk;
    logic                  reset;
    logic                  retired;
    logic [NUM_EVENTS-1:0] events;
    logic                  re;
    logic [11:0]           ra;
    logic [31:0]           rdata;
    logic                  rhit;
    logic                  we;
    logic [11:0]           wa;
    logic [31:0]           wd;
    logic                  ill;

    csr_perf_counters #(.NUM_HPM(NUM_HPM), .NUM_EVENTS(NUM_EVENTS)) dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .retired_i           (retired),
        .events_i            (events),
        .csr_read_enable_i   (re),
        .csr_read_addr_i     (ra),
        .csr_read_data_o     (rdata),
        .csr_read_hit_o      (rhit),
        .csr_write_enable_i  (we),
        .csr_write_addr_i    (wa),
        .csr_write_data_i    (wd),
        .csr_write_illegal_o (ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural state indexed by CSR number: 0 = mcycle, 2 = minstret, 3.. = hpm.
    logic [63:0] m_ctr [0:31];
    logic [31:0] m_ev  [0:31];
    logic [31:0] m_inh;
    logic [31:0] exp_data;
    logic        exp_hit;
    logic        exp_ill;

    logic        chk_en;
    logic        lit_en;
    logic [31:0] lit_data;
    logic        lit_hit;
    logic        lit_ill_en;
    logic        lit_ill;
    string       lit_name;
    int          n_vec;
    int          n_err;

    function automatic logic implemented(input logic [4:0] n);
        return (n == 5'd0) || (n == 5'd2) || ((32'(n) >= 3) && (32'(n) < 3 + NUM_HPM));
    endfunction

    function automatic void model_read(input logic [11:0] a, output logic [31:0] d, output logic h);
        logic [63:0] v;
        logic [4:0]  n;
        n = a[4:0];
        d = '0;
        h = 1'b0;
        v = '0;
        if (a inside {[12'hB00:12'hB1F], [12'hB80:12'hB9F], [12'hC00:12'hC1F], [12'hC80:12'hC9F]}) begin
            if (!((n == 5'd1) && (a[11:8] == 4'hB))) begin
                h = 1'b1;
                if (n == 5'd1)         v = m_ctr[0];
                else if (implemented(n)) v = m_ctr[n];
                d = a[7] ? v[63:32] : v[31:0];
            end
        end else if (a == 12'h320) begin
            h = 1'b1;
            d = m_inh;
        end else if (a inside {[12'h323:12'h33F]}) begin
            h = 1'b1;
            if (implemented(n)) d = m_ev[n];
        end
    endfunction

    task automatic model_step();
        logic [63:0] nxt [0:31];
        logic        inc;
        logic [31:0] e;
        logic [4:0]  n;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_ctr[i] = '0;
                m_ev[i]  = '0;
            end
            m_inh    = '0;
            exp_data = '0;
            exp_hit  = 1'b0;
            exp_ill  = 1'b0;
            return;
        end
        if (re) model_read(ra, exp_data, exp_hit);
        exp_ill = we && (wa[11:8] == 4'hC);
        for (int i = 0; i < 32; i++) begin
            inc = 1'b0;
            if (i == 0) inc = !m_inh[0];
            else if (i == 2) inc = retired && !m_inh[2];
            else if (i >= 3 && i < 3 + NUM_HPM) begin
                e   = m_ev[i];
                inc = !m_inh[i] && (e >= 1) && (e <= NUM_EVENTS) &&
                      (((32'(events) >> (e - 32'd1)) & 32'd1) != 0);
            end
            nxt[i] = m_ctr[i] + 64'(inc);
        end
        if (we && (wa[11:8] != 4'hC)) begin
            n = wa[4:0];
            if ((wa inside {[12'hB00:12'hB1F], [12'hB80:12'hB9F]}) && implemented(n))
                nxt[n] = wa[7] ? {wd, m_ctr[n][31:0]} : {m_ctr[n][63:32], wd};
            else if (wa == 12'h320)
                m_inh = wd & INH_MASK;
            else if ((wa inside {[12'h323:12'h33F]}) && implemented(n))
                m_ev[n] = wd;
        end
        for (int i = 0; i < 32; i++) m_ctr[i] = nxt[i];
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (rdata !== exp_data) begin
                n_err++;
                $display("FAIL rd_data @%0t addr=%h got=%h expected=%h", $time, ra, rdata, exp_data);
            end
            n_vec++;
            if (rhit !== exp_hit) begin
                n_err++;
                $display("FAIL rd_hit @%0t got=%b expected=%b", $time, rhit, exp_hit);
            end
            n_vec++;
            if (ill !== exp_ill) begin
                n_err++;
                $display("FAIL wr_illegal @%0t got=%b expected=%b", $time, ill, exp_ill);
            end
            if (lit_en) begin
                n_vec++;
                if ((rdata !== lit_data) || (rhit !== lit_hit)) begin
                    n_err++;
                    $display("FAIL %s got data=%h hit=%b expected data=%h hit=%b",
                             lit_name, rdata, rhit, lit_data, lit_hit);
                end
            end
            if (lit_ill_en) begin
                n_vec++;
                if (ill !== lit_ill) begin
                    n_err++;
                    $display("FAIL %s got illegal=%b expected=%b", lit_name, ill, lit_ill);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic quiet();
        re = 1'b0; we = 1'b0; reset = 1'b0; retired = 1'b0; events = '0;
        ra = '0; wa = '0; wd = '0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        we = 1'b1; wa = a; wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd_lit(input logic [11:0] a, input logic [31:0] d, input logic h, input string name);
        re = 1'b1; ra = a;
        lit_en = 1'b1; lit_data = d; lit_hit = h; lit_name = name;
        tick();
        re = 1'b0; lit_en = 1'b0;
    endtask

    function automatic logic [11:0] pick_addr();
        case ($urandom_range(0, 15))
            0:  return 12'hB00;
            1:  return 12'hB80;
            2:  return 12'hB02;
            3:  return 12'hB82;
            4:  return 12'hB00 | 12'($urandom_range(3, 31));
            5:  return 12'hB80 | 12'($urandom_range(3, 31));
            6:  return 12'h320;
            7:  return 12'h323 + 12'($urandom_range(0, 28));
            8:  return 12'hC00 | 12'($urandom_range(0, 31));
            9:  return 12'hC80 | 12'($urandom_range(0, 31));
            10: return ($urandom_range(0, 1) == 0) ? 12'hB01 : 12'hB81;
            11: return 12'h7C0;
            12: return 12'($urandom);
            13: return 12'hB03 + 12'($urandom_range(0, NUM_HPM - 1));
            14: return 12'hB83 + 12'($urandom_range(0, NUM_HPM - 1));
            default: return 12'h323 + 12'($urandom_range(0, NUM_HPM - 1));
        endcase
    endfunction

    initial begin
        n_vec = 0; n_err = 0;
        chk_en = 1'b0; lit_en = 1'b0; lit_ill_en = 1'b0; lit_ill = 1'b0;
        lit_data = '0; lit_hit = 1'b0; lit_name = "";
        quiet();

        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        rd_lit(12'hB00, 32'd0, 1'b0, "reset_outputs");
        reset = 1'b0;

        for (int i = 0; i < 10; i++) tick();
        rd_lit(12'hB00, 32'd10, 1'b1, "mcycle_after_10_idle");
        rd_lit(12'hB02, 32'd0, 1'b1, "minstret_idle");

        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'hFFFF_FFFF);
        tick();
        tick();
        rd_lit(12'hB00, 32'd1, 1'b1, "mcycle_wrap_lo");
        rd_lit(12'hB80, 32'd0, 1'b1, "mcycle_wrap_hi");

        wr(12'hB03, 32'd0);
        wr(12'hB83, 32'd0);
        wr(12'h323, 32'd2);
        for (int i = 0; i < 5; i++) begin events = 8'b0000_0010; tick(); end
        for (int i = 0; i < 3; i++) begin events = 8'b0000_0001; tick(); end
        events = '0;
        rd_lit(12'hB03, 32'd5, 1'b1, "hpm3_event2_count");
        rd_lit(12'h323, 32'd2, 1'b1, "mhpmevent3_readback");
        lit_en = 1'b1; lit_data = 32'd2; lit_hit = 1'b1; lit_name = "read_hold";
        tick();
        lit_en = 1'b0;

        wr(12'h320, 32'h5);
        wr(12'hB00, 32'h1234);
        wr(12'hB02, 32'h55);
        retired = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        rd_lit(12'hB00, 32'h1234, 1'b1, "mcycle_inhibited");
        rd_lit(12'hB02, 32'h55, 1'b1, "minstret_inhibited");
        retired = 1'b0;
        wr(12'h320, 32'hFFFF_FFFF);
        rd_lit(12'h320, 32'h7D, 1'b1, "mcountinhibit_mask");
        wr(12'h320, 32'h0);

        retired = 1'b1;
        wr(12'hB02, 32'd100);
        retired = 1'b0;
        rd_lit(12'hB02, 32'd100, 1'b1, "minstret_write_wins");

        lit_ill_en = 1'b1; lit_ill = 1'b1; lit_name = "illegal_set";
        wr(12'hC00, 32'd7);
        lit_ill = 1'b0; lit_name = "illegal_clear";
        tick();
        lit_ill_en = 1'b0;
        rd_lit(12'hB1F, 32'd0, 1'b1, "mhpmcounter31_roz");
        rd_lit(12'h7C0, 32'd0, 1'b0, "unmapped_7c0");
        rd_lit(12'h33F, 32'd0, 1'b1, "mhpmevent31_roz");

        for (int c = 0; c < 4000; c++) begin
            reset   = ($urandom_range(0, 299) == 0);
            retired = 1'($urandom_range(0, 1));
            events  = NUM_EVENTS'($urandom);
            re      = ($urandom_range(0, 3) != 0);
            ra      = pick_addr();
            we      = ($urandom_range(0, 3) == 0);
            wa      = pick_addr();
            case ($urandom_range(0, 3))
                0:       wd = $urandom;
                1:       wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: wd = 32'($urandom_range(0, 10));
            endcase
            tick();
        end
        quiet();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
